// File: rtl/cpu_debug_ocimem_ctrl_pkg.sv
// Shared types and JTAG data-word field positions for the OCI debug memory controller.
package cpu_debug_pkg;

   typedef enum logic [1:0] {
      J_IDLE       = 2'd0,
      J_RD_ISSUE   = 2'd1,
      J_RD_CAPTURE = 2'd2
   } j_state_e;

   typedef enum logic {
      C_IDLE = 1'b0,
      C_RD   = 1'b1
   } c_state_e;

   localparam int JDO_ADDR_LSB   = 10;
   localparam int JDO_RD_BIT     = 34;
   localparam int JDO_CLRERR_BIT = 35;
   localparam int JDO_WDATA_LSB  = 3;
   localparam int JDO_WDATA_MSB  = 34;

endpackage

// File: rtl/cpu_debug_ocimem_ctrl_if.sv
// CPU-side Avalon-MM slave bus into the OCI debug memory.
interface cpu_debug_ocimem_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic [3:0]        avs_byteenable;
   logic [31:0]       avs_readdata;
   logic              avs_waitrequest;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      input  avs_readdata, avs_waitrequest
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      output avs_readdata, avs_waitrequest
   );
endinterface

// File: rtl/cpu_debug_ocimem_ram.sv
// Single-port DEPTHx32 byte-enabled RAM with one-cycle registered read.
// Addresses at or beyond DEPTH read as zero and ignore writes.
module cpu_debug_ocimem_ram #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   input  logic [3:0]        be,
   input  logic [31:0]       wdata,
   output logic [31:0]       q
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [31:0]      mem [DEPTH];
   logic             in_range_s;
   logic [IDX_W-1:0] idx_s;

   assign in_range_s = ({1'b0, addr} < DEPTH_L);
   assign idx_s      = addr[IDX_W-1:0];

   // Storage array: byte-lane writes and registered read port.
   always_ff @(posedge clk) begin
      if (wr && in_range_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[idx_s][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      if (rd) begin
         q <= in_range_s ? mem[idx_s] : 32'h0000_0000;
      end
   end
endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// JTAG-driven reads/writes of the OCI debug RAM, sharing the single RAM port
// with a CPU Avalon-MM slave; the JTAG side always wins the port.
module cpu_debug_ocimem_ctrl
   import cpu_debug_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [37:0]                   jdo,
   input  logic                          take_action_ocimem_a,
   input  logic                          take_action_ocimem_b,
   input  logic                          take_no_action_ocimem_a,
   cpu_debug_ocimem_ctrl_if.slave        avs,
   output logic [31:0]                   MonDReg,
   output logic                          monitor_ready,
   output logic                          monitor_error
);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   j_state_e          j_state_r, j_state_s;
   c_state_e          c_state_r, c_state_s;
   logic [ADDR_W-1:0] jaddr_r;

   logic        j_idle_s, j_issue_s, j_capture_s;
   logic        any_strobe_s, multi_strobe_s;
   logic        jwrite_s, ja_cmd_s, jrd_start_s, jport_s;
   logic        jaddr_ok_s, err_set_s, err_clr_s;
   logic        cpu_rd_s, cpu_wr_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic        ram_rd_s, ram_wr_s;
   logic [3:0]  ram_be_s;
   logic [31:0] ram_wdata_s, ram_q_s;
   logic        unused_jdo_s;

   assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

   assign j_idle_s       = (j_state_r == J_IDLE);
   assign j_issue_s      = (j_state_r == J_RD_ISSUE);
   assign j_capture_s    = (j_state_r == J_RD_CAPTURE);
   assign any_strobe_s   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign multi_strobe_s = (take_action_ocimem_a & take_action_ocimem_b)
                         | (take_action_ocimem_a & take_no_action_ocimem_a)
                         | (take_action_ocimem_b & take_no_action_ocimem_a);

   // Priority b > a > no_action; only honoured in J_IDLE.
   assign jwrite_s    = ~reset & j_idle_s & take_action_ocimem_b;
   assign ja_cmd_s    = ~reset & j_idle_s & ~take_action_ocimem_b & take_action_ocimem_a;
   assign jrd_start_s = (ja_cmd_s & jdo[JDO_RD_BIT])
                      | (~reset & j_idle_s & ~take_action_ocimem_b & ~take_action_ocimem_a
                         & take_no_action_ocimem_a);
   assign jport_s     = jwrite_s | j_issue_s;
   assign jaddr_ok_s  = ({1'b0, jaddr_r} < DEPTH_L);

   assign err_set_s = multi_strobe_s
                    | (~j_idle_s & any_strobe_s)
                    | (jwrite_s & ~jaddr_ok_s)
                    | (j_capture_s & ~jaddr_ok_s);
   assign err_clr_s = ja_cmd_s & jdo[JDO_CLRERR_BIT];

   // JTAG FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         j_state_r <= J_IDLE;
      end else begin
         j_state_r <= j_state_s;
      end
   end

   // JTAG FSM next state.
   always_comb begin
      j_state_s = j_state_r;
      case (j_state_r)
         J_IDLE: begin
            if (jrd_start_s) begin
               j_state_s = J_RD_ISSUE;
            end else begin
               j_state_s = J_IDLE;
            end
         end
         J_RD_ISSUE:   j_state_s = J_RD_CAPTURE;
         J_RD_CAPTURE: j_state_s = J_IDLE;
         default:      j_state_s = J_IDLE;
      endcase
   end

   // JTAG address pointer, read-data register and monitor status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         jaddr_r       <= '0;
         MonDReg       <= 32'h0000_0000;
         monitor_ready <= 1'b1;
         monitor_error <= 1'b0;
      end else begin
         if (jwrite_s) begin
            jaddr_r <= jaddr_r + ADDR_W'(1);
         end else if (ja_cmd_s) begin
            jaddr_r <= jdo[JDO_ADDR_LSB +: ADDR_W];
         end else if (j_capture_s) begin
            jaddr_r <= jaddr_r + ADDR_W'(1);
            MonDReg <= ram_q_s;
         end
         if (jrd_start_s) begin
            monitor_ready <= 1'b0;
         end else if (j_capture_s) begin
            monitor_ready <= 1'b1;
         end
         if (err_set_s) begin
            monitor_error <= 1'b1;
         end else if (err_clr_s) begin
            monitor_error <= 1'b0;
         end
      end
   end

   // CPU FSM state register and read-data capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         c_state_r        <= C_IDLE;
         avs.avs_readdata <= 32'h0000_0000;
      end else begin
         c_state_r <= c_state_s;
         if (c_state_r == C_RD) begin
            avs.avs_readdata <= ram_q_s;
         end
      end
   end

   // CPU FSM next state, grant and stall; read wins over a simultaneous write.
   always_comb begin
      c_state_s           = c_state_r;
      avs.avs_waitrequest = 1'b1;
      cpu_rd_s            = 1'b0;
      cpu_wr_s            = 1'b0;
      if (reset) begin
         c_state_s = C_IDLE;
      end else begin
         case (c_state_r)
            C_IDLE: begin
               if (avs.avs_read && !jport_s) begin
                  cpu_rd_s  = 1'b1;
                  c_state_s = C_RD;
               end else if (avs.avs_write && !avs.avs_read && !jport_s) begin
                  cpu_wr_s            = 1'b1;
                  avs.avs_waitrequest = 1'b0;
               end else begin
                  avs.avs_waitrequest = 1'b1;
               end
            end
            C_RD: begin
               avs.avs_waitrequest = 1'b0;
               c_state_s           = C_IDLE;
            end
            default: c_state_s = C_IDLE;
         endcase
      end
   end

   // RAM port mux.
   always_comb begin
      ram_addr_s  = avs.avs_address;
      ram_wdata_s = avs.avs_writedata;
      ram_be_s    = avs.avs_byteenable;
      ram_rd_s    = j_issue_s | cpu_rd_s;
      ram_wr_s    = jwrite_s | cpu_wr_s;
      if (jport_s) begin
         ram_addr_s  = jaddr_r;
         ram_wdata_s = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
         ram_be_s    = 4'hF;
      end else begin
         ram_addr_s  = avs.avs_address;
      end
   end

   cpu_debug_ocimem_ram #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr_s),
      .rd    (ram_rd_s),
      .wr    (ram_wr_s),
      .be    (ram_be_s),
      .wdata (ram_wdata_s),
      .q     (ram_q_s)
   );
endmodule
